// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
// Used by multiport_regfile and rf_clear_ctrl.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  function automatic logic addr_in_range(
    input int addr,
    input int depth
  );
    return addr < depth;
  endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear sequencer: walks every entry to zero after reset,
// then raises ready and hands the array to the user ports.
module rf_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output rf_state_t         state,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_ready;
  logic              w_ready_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_CLEAR;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // The array is left alone on reset edges; only the sweep clears it.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_ready_nxt = r_ready;
    clr_we      = 1'b0;
    unique case (r_state)
      RF_CLEAR: begin
        clr_we    = !rst;
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (r_ptr == LAST) begin
          w_state_nxt = RF_RUN;
          w_ready_nxt = 1'b1;
          w_ptr_nxt   = '0;
        end
      end
      RF_RUN: begin
        w_state_nxt = RF_RUN;
      end
      default: begin
        w_state_nxt = RF_CLEAR;
      end
    endcase
  end

  assign clr_addr = r_ptr;
  assign state    = r_state;
  assign ready    = r_ready;

endmodule

// File: rtl/multiport_regfile.sv
// GPR store: one write port, NUM_RD registered read ports with
// write-first bypass. REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int NUM_RD     = 2,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [NUM_RD-1:0]                  rd_en,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic                               ready
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic                                w_clr_we;
  logic [ADDR_W-1:0]                   w_clr_addr;
  rf_state_t                           w_state;
  logic                                w_wr_ok;
  logic                                w_we;
  logic [ADDR_W-1:0]                   w_waddr;
  logic [DATA_WIDTH-1:0]               w_wdata;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]   w_rd_nxt;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]   r_rd;
  logic [DATA_WIDTH-1:0]               r_gpr [DEPTH];

  rf_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .state    (w_state),
    .ready    (ready)
  );

  assign w_wr_ok = we && !rst && (w_state == RF_RUN)
                && addr_in_range(32'(wr_addr), DEPTH)
                && !(ZERO_REG && (wr_addr == '0));

  assign w_we    = w_clr_we || w_wr_ok;
  assign w_waddr = w_clr_we ? w_clr_addr : wr_addr;
  assign w_wdata = w_clr_we ? '0 : wr_data;

  // No reset on the array so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_gpr[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    w_rd_nxt = r_rd;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_en[i]) begin
        w_rd_nxt[i] = '0;
        if (addr_in_range(32'(rd_addr[i]), DEPTH)
            && !(ZERO_REG && (rd_addr[i] == '0))) begin
          if (w_wr_ok && (rd_addr[i] == wr_addr)) begin
            w_rd_nxt[i] = wr_data;
          end else begin
            w_rd_nxt[i] = r_gpr[rd_addr[i]];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (w_state == RF_CLEAR)) begin
      r_rd <= '0;
    end else begin
      r_rd <= w_rd_nxt;
    end
  end

  assign rd_data = r_rd;

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: directed vectors, random traffic vs model,
// and a DEPTH=6 instance for out-of-range addressing.
module tb_multiport_regfile;

  localparam int D  = 8;
  localparam int NR = 2;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            we;
  logic [2:0]      wr_addr;
  logic [7:0]      wr_data;
  logic [1:0]      rd_en;
  logic [1:0][2:0] rd_addr;
  logic [1:0][7:0] rd_data;
  logic            ready;

  logic            we6;
  logic [2:0]      wa6;
  logic [7:0]      wd6;
  logic [1:0]      en6;
  logic [1:0][2:0] ra6;
  logic [1:0][7:0] rd6;
  logic            ready6;

  multiport_regfile #(
    .DATA_WIDTH (8),
    .DEPTH      (D),
    .NUM_RD     (NR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ready   (ready)
  );

  multiport_regfile #(
    .DATA_WIDTH (8),
    .DEPTH      (6),
    .NUM_RD     (2)
  ) dut6 (
    .clk     (clk),
    .rst     (rst),
    .we      (we6),
    .wr_addr (wa6),
    .wr_data (wd6),
    .rd_en   (en6),
    .rd_addr (ra6),
    .rd_data (rd6),
    .ready   (ready6)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_arr [D];
  logic [7:0] m_rd  [NR];
  int         m_clr;
  bit         m_ready;

  typedef struct {
    bit we;
    int wa;
    int wd;
    int en;
    int ra0;
    int ra1;
    int e0;
    int e1;
  } vec_t;

  vec_t tv [8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mread(int ra, bit w, int wa, int wd);
    if (ra >= D || (ZR && ra == 0)) return 8'h00;
    if (w && wa == ra) return 8'(wd);
    return m_arr[ra];
  endfunction

  // Drive one cycle at the negedge, advance the model, sample next negedge.
  task automatic step(bit r, bit w, int wa, int wd, int en, int ra0, int ra1);
    int ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    rst = r;
    we = w;
    wr_addr = 3'(wa);
    wr_data = 8'(wd);
    rd_en = 2'(en);
    rd_addr[0] = 3'(ra0);
    rd_addr[1] = 3'(ra1);
    if (r) begin
      m_rd[0] = 8'h00;
      m_rd[1] = 8'h00;
      m_ready = 1'b0;
      m_clr = 0;
    end else if (!m_ready) begin
      m_arr[m_clr] = 8'h00;
      m_clr++;
      m_ready = (m_clr == D);
      m_rd[0] = 8'h00;
      m_rd[1] = 8'h00;
    end else begin
      for (int i = 0; i < NR; i++)
        if (en[i]) m_rd[i] = mread(ra[i], w, wa, wd);
      if (w && wa < D && !(ZR && wa == 0)) m_arr[wa] = 8'(wd);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mcheck(string tag);
    chk({tag, "_rd0"}, 32'(rd_data[0]), 32'(m_rd[0]));
    chk({tag, "_rd1"}, 32'(rd_data[1]), 32'(m_rd[1]));
    chk({tag, "_ready"}, 32'(ready), 32'(m_ready));
  endtask

  task automatic step6(bit w, int wa, int wd, int en, int ra0, int ra1);
    we6 = w;
    wa6 = 3'(wa);
    wd6 = 8'(wd);
    en6 = 2'(en);
    ra6[0] = 3'(ra0);
    ra6[1] = 3'(ra1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1;
    we = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en = '0;
    rd_addr = '0;
    we6 = 1'b0;
    wa6 = '0;
    wd6 = '0;
    en6 = '0;
    ra6 = '0;
    for (int i = 0; i < D; i++) m_arr[i] = 8'h00;
    m_rd[0] = 8'h00;
    m_rd[1] = 8'h00;
    m_clr = 0;
    m_ready = 1'b0;
    @(negedge clk);

    // Reset, sweep timing, writes ignored during the sweep
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_rd0", 32'(rd_data[0]), 0);
    chk("rst_rd1", 32'(rd_data[1]), 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 2, 'hFF, 3, k - 1, 8 - k);
      chk("sweep_ready", 32'(ready), 32'(k == 8));
      chk("sweep_rd0", 32'(rd_data[0]), 0);
      chk("sweep_ready6", 32'(ready6), 32'(k >= 6));
    end
    for (int a = 0; a < 8; a++) begin
      step(0, 0, 0, 0, 3, a, 7 - a);
      chk("clr_rd0", 32'(rd_data[0]), 0);
      chk("clr_rd1", 32'(rd_data[1]), 0);
    end

    // Directed vectors: write/read, bypass, hold, entry 0
    tv[0] = '{1, 3, 'hA5, 0, 0, 0, 'h00, 'h00};
    tv[1] = '{0, 0, 0, 3, 3, 4, 'hA5, 'h00};
    tv[2] = '{1, 5, 'h3C, 3, 5, 5, 'h3C, 'h3C};
    tv[3] = '{0, 0, 0, 3, 5, 5, 'h3C, 'h3C};
    tv[4] = '{0, 0, 0, 1, 3, 0, 'hA5, 'h3C};
    tv[5] = '{0, 0, 0, 2, 3, 0, 'hA5, 'h00};
    tv[6] = '{1, 0, 'h11, 3, 0, 3, ZR ? 'h00 : 'h11, 'hA5};
    tv[7] = '{0, 0, 0, 1, 0, 3, ZR ? 'h00 : 'h11, 'hA5};
    for (int i = 0; i < 8; i++) begin
      step(0, tv[i].we, tv[i].wa, tv[i].wd, tv[i].en, tv[i].ra0, tv[i].ra1);
      chk($sformatf("vec%0d_rd0", i), 32'(rd_data[0]), 32'(tv[i].e0));
      chk($sformatf("vec%0d_rd1", i), 32'(rd_data[1]), 32'(tv[i].e1));
    end

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
           $urandom_range(0, 255), $urandom_range(0, 3),
           $urandom_range(0, 7), $urandom_range(0, 7));
      mcheck("rnd");
    end

    // Reset in RUN, then again mid-sweep
    step(0, 1, 3, 'h12, 0, 0, 0);
    step(0, 1, 5, 'h34, 0, 0, 0);
    step(0, 0, 0, 0, 3, 3, 5);
    chk("pre_rst_rd0", 32'(rd_data[0]), 'h12);
    chk("pre_rst_rd1", 32'(rd_data[1]), 'h34);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rerun_ready", 32'(ready), 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    cnt = 0;
    while (!ready && cnt < 20) begin
      step(0, 0, 0, 0, 0, 0, 0);
      cnt++;
    end
    chk("restart_latency", 32'(cnt), 8);
    step(0, 0, 0, 0, 3, 3, 5);
    chk("post_rst_rd0", 32'(rd_data[0]), 0);
    chk("post_rst_rd1", 32'(rd_data[1]), 0);
    mcheck("post_rst");

    // DEPTH=6 instance: out-of-range writes and reads
    chk("d6_ready", 32'(ready6), 1);
    step6(1, 7, 'h77, 0, 0, 0);
    step6(0, 0, 0, 1, 7, 0);
    chk("d6_oor_rd", 32'(rd6[0]), 0);
    step6(1, 0, 'h11, 3, 0, 0);
    chk("d6_z_byp0", 32'(rd6[0]), ZR ? 0 : 'h11);
    chk("d6_z_byp1", 32'(rd6[1]), ZR ? 0 : 'h11);
    step6(1, 5, 'h5A, 2, 0, 5);
    chk("d6_last_byp", 32'(rd6[1]), 'h5A);
    step6(0, 0, 0, 3, 0, 5);
    chk("d6_z_arr", 32'(rd6[0]), ZR ? 0 : 'h11);
    chk("d6_last_arr", 32'(rd6[1]), 'h5A);
    step6(0, 0, 0, 3, 6, 7);
    chk("d6_oor6", 32'(rd6[0]), 0);
    chk("d6_oor7", 32'(rd6[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
